// File: rtl/camera_capture.sv
// Captures one RGB565 camera frame per request into BRAM as RGB444.
// Inputs are registered once; all sync-edge detection uses the registered copies.
module camera_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_start,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [11:0]       bram_wdata,
    output logic              busy,
    output logic              frame_done,
    output logic              display_enable,
    output logic [ADDR_W-1:0] pixel_count
);

    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam logic [XW-1:0]     X_LIMIT = XW'(H_ACTIVE);
    localparam logic [YW-1:0]     Y_LIMIT = YW'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_ACTIVE);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VSYNC,
        CAPTURE,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic       vsync_q, vsync_d;
    logic       href_q, href_d;
    logic [7:0] data_q, data_d;
    logic       vsync_prev_q, vsync_prev_d;
    logic       href_prev_q, href_prev_d;

    logic              phase_q, phase_d;
    logic [6:0]        hi_q, hi_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [11:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] pixel_count_q, pixel_count_d;
    logic              display_enable_q, display_enable_d;

    logic vsync_fall, vsync_rise, href_fall;

    assign vsync_fall = vsync_prev_q & ~vsync_q;
    assign vsync_rise = ~vsync_prev_q & vsync_q;
    assign href_fall  = href_prev_q & ~href_q;

    always_comb begin
        state_d          = state_q;
        vsync_d          = cam_vsync;
        href_d           = cam_href;
        data_d           = cam_data;
        vsync_prev_d     = vsync_q;
        href_prev_d      = href_q;
        phase_d          = phase_q;
        hi_d             = hi_q;
        x_d              = x_q;
        y_d              = y_q;
        row_base_d       = row_base_q;
        we_d             = 1'b0;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        pixel_count_d    = pixel_count_q;
        display_enable_d = display_enable_q;

        case (state_q)
            IDLE: begin
                if (capture_start) begin
                    state_d          = WAIT_VSYNC;
                    display_enable_d = 1'b0;
                end
            end

            WAIT_VSYNC: begin
                if (vsync_fall) begin
                    state_d       = CAPTURE;
                    x_d           = '0;
                    y_d           = '0;
                    row_base_d    = '0;
                    phase_d       = 1'b0;
                    pixel_count_d = '0;
                end
            end

            CAPTURE: begin
                if (vsync_rise) begin
                    state_d          = DONE;
                    display_enable_d = 1'b1;
                end
                // A byte arriving on the closing vsync edge is still processed so its write completes.
                if (href_q) begin
                    if (!phase_q) begin
                        hi_d    = {data_q[7:4], data_q[2:0]};
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (x_q < X_LIMIT && y_q < Y_LIMIT) begin
                            we_d          = 1'b1;
                            addr_d        = row_base_q + ADDR_W'(x_q);
                            wdata_d       = {hi_q[6:3], hi_q[2:0], data_q[7], data_q[4:1]};
                            x_d           = x_q + XW'(1);
                            pixel_count_d = pixel_count_q + ADDR_W'(1);
                        end
                    end
                end else if (href_fall) begin
                    x_d     = '0;
                    phase_d = 1'b0;
                    if (y_q < Y_LIMIT) begin
                        y_d        = y_q + YW'(1);
                        row_base_d = row_base_q + ROW_STEP;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            vsync_q          <= 1'b0;
            href_q           <= 1'b0;
            data_q           <= '0;
            vsync_prev_q     <= 1'b0;
            href_prev_q      <= 1'b0;
            phase_q          <= 1'b0;
            hi_q             <= '0;
            x_q              <= '0;
            y_q              <= '0;
            row_base_q       <= '0;
            we_q             <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            pixel_count_q    <= '0;
            display_enable_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            vsync_q          <= vsync_d;
            href_q           <= href_d;
            data_q           <= data_d;
            vsync_prev_q     <= vsync_prev_d;
            href_prev_q      <= href_prev_d;
            phase_q          <= phase_d;
            hi_q             <= hi_d;
            x_q              <= x_d;
            y_q              <= y_d;
            row_base_q       <= row_base_d;
            we_q             <= we_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            pixel_count_q    <= pixel_count_d;
            display_enable_q <= display_enable_d;
        end
    end

    assign bram_we        = we_q;
    assign bram_addr      = addr_q;
    assign bram_wdata     = wdata_q;
    assign pixel_count    = pixel_count_q;
    assign display_enable = display_enable_q;
    assign busy           = (state_q == WAIT_VSYNC) || (state_q == CAPTURE);
    assign frame_done     = (state_q == DONE);

endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture on a reduced 16x4 frame: reset, latency,
// colour conversion, overlong/short lines, frame completion and mid-frame reset.
module tb_camera_capture;

    localparam int H  = 16;
    localparam int V  = 4;
    localparam int AW = 10;

    logic          clk;
    logic          rst;
    logic          capture_start;
    logic          cam_vsync;
    logic          cam_href;
    logic [7:0]    cam_data;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [11:0]   bram_wdata;
    logic          busy;
    logic          frame_done;
    logic          display_enable;
    logic [AW-1:0] pixel_count;

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] wr_addr[$];
    logic [11:0]   wr_data[$];
    int            done_count = 0;
    int            we_outside = 0;

    camera_capture #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .ADDR_W  (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .capture_start (capture_start),
        .cam_vsync     (cam_vsync),
        .cam_href      (cam_href),
        .cam_data      (cam_data),
        .bram_we       (bram_we),
        .bram_addr     (bram_addr),
        .bram_wdata    (bram_wdata),
        .busy          (busy),
        .frame_done    (frame_done),
        .display_enable(display_enable),
        .pixel_count   (pixel_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write/pulse log sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (bram_we) begin
            wr_addr.push_back(bram_addr);
            wr_data.push_back(bram_wdata);
        end
        if (frame_done) done_count++;
        if (bram_we && !busy) we_outside++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic h, input logic [7:0] d);
        cam_vsync = v;
        cam_href  = h;
        cam_data  = d;
        step();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic sendLine(input int nbytes, input logic [7:0] hi, input logic [7:0] lo);
        for (int i = 0; i < nbytes; i++) applyStimulus(1'b0, 1'b1, (i % 2 == 0) ? hi : lo);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        rst           = 1'b1;
        capture_start = 1'b0;
        cam_vsync     = 1'b1;
        cam_href      = 1'b0;
        cam_data      = 8'h00;
        step();
        step();
        step();

        checkOutput("rst_we",    32'(bram_we),        32'd0);
        checkOutput("rst_busy",  32'(busy),           32'd0);
        checkOutput("rst_done",  32'(frame_done),     32'd0);
        checkOutput("rst_de",    32'(display_enable), 32'd0);
        checkOutput("rst_addr",  32'(bram_addr),      32'd0);
        checkOutput("rst_wdata", 32'(bram_wdata),     32'd0);
        checkOutput("rst_pcnt",  32'(pixel_count),    32'd0);
        rst = 1'b0;
        step();

        // Frame 1
        capture_start = 1'b1;
        step();
        capture_start = 1'b0;
        checkOutput("busy_wait", 32'(busy), 32'd1);
        capture_start = 1'b1;
        step();
        capture_start = 1'b0;
        checkOutput("busy_ignore", 32'(busy), 32'd1);
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("busy_capture", 32'(busy), 32'd1);

        // Line 0: single pixel, write latency measured from the phase-1 byte.
        applyStimulus(1'b0, 1'b1, 8'hF8);
        applyStimulus(1'b0, 1'b1, 8'h00);
        cam_href = 1'b0;
        cam_data = 8'h00;
        checkOutput("lat_n1_we", 32'(bram_we), 32'd0);
        step();
        checkOutput("lat_n2_we",    32'(bram_we),    32'd1);
        checkOutput("lat_n2_addr",  32'(bram_addr),  32'd0);
        checkOutput("lat_n2_wdata", 32'(bram_wdata), 32'hF00);
        step();
        checkOutput("lat_n3_we", 32'(bram_we), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00);

        // Line 1: colour patterns.
        applyStimulus(1'b0, 1'b1, 8'h07);
        applyStimulus(1'b0, 1'b1, 8'hE0);
        applyStimulus(1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h1F);
        applyStimulus(1'b0, 1'b1, 8'hFF);
        applyStimulus(1'b0, 1'b1, 8'hFF);
        applyStimulus(1'b0, 1'b1, 8'hF8);
        applyStimulus(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00);

        capture_start = 1'b1;
        step();
        capture_start = 1'b0;

        // Line 2 overlong (36 bytes), line 3 three bytes, line 4 beyond V_ACTIVE.
        sendLine(2 * H + 4, 8'h12, 8'h34);
        sendLine(3, 8'hAB, 8'hCD);
        sendLine(2, 8'hFF, 8'hFF);

        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 10 && !frame_done; i++) step();
        checkOutput("frame_done_seen", 32'(frame_done),     32'd1);
        checkOutput("de_on_done",      32'(display_enable), 32'd1);
        checkOutput("pcnt_frame1",     32'(pixel_count),    32'd22);
        step();
        checkOutput("done_one_cycle", 32'(frame_done), 32'd0);
        checkOutput("idle_after",     32'(busy),       32'd0);
        for (int i = 0; i < 4; i++) step();
        checkOutput("stay_idle",   32'(busy),           32'd0);
        checkOutput("de_hold",     32'(display_enable), 32'd1);
        checkOutput("pcnt_hold",   32'(pixel_count),    32'd22);
        checkOutput("done_count1", 32'(done_count),     32'd1);
        checkOutput("we_outside1", 32'(we_outside),     32'd0);

        checkOutput("wr_total1", 32'(wr_addr.size()), 32'd22);
        if (wr_addr.size() == 22) begin
            checkOutput("c1_addr", 32'(wr_addr[1]), 32'd16);
            checkOutput("c1_data", 32'(wr_data[1]), 32'h0F0);
            checkOutput("c2_addr", 32'(wr_addr[2]), 32'd17);
            checkOutput("c2_data", 32'(wr_data[2]), 32'h00F);
            checkOutput("c3_data", 32'(wr_data[3]), 32'hFFF);
            checkOutput("c4_addr", 32'(wr_addr[4]), 32'd19);
            checkOutput("c4_data", 32'(wr_data[4]), 32'hF00);
            for (int k = 0; k < H; k++) begin
                checkOutput($sformatf("row2_addr%0d", k), 32'(wr_addr[5 + k]), 32'(2 * H + k));
                checkOutput($sformatf("row2_data%0d", k), 32'(wr_data[5 + k]), 32'h14A);
            end
            checkOutput("short_addr", 32'(wr_addr[21]), 32'd48);
            checkOutput("short_data", 32'(wr_data[21]), 32'hA76);
        end

        // Frame 2: re-arm drops display_enable, then reset mid-frame.
        wr_addr.delete();
        wr_data.delete();
        capture_start = 1'b1;
        step();
        capture_start = 1'b0;
        checkOutput("de_drop",    32'(display_enable), 32'd0);
        checkOutput("busy_rearm", 32'(busy),           32'd1);
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("pcnt_clear", 32'(pixel_count), 32'd0);
        sendLine(2 * H, 8'hFF, 8'hFF);
        for (int i = 0; i < 20; i++) begin
            cam_vsync = 1'b0;
            cam_href  = 1'b1;
            cam_data  = 8'h55;
            if (i == 10) begin
                checkOutput("pcnt_mid", 32'(pixel_count), 32'd20);
                rst = 1'b1;
            end
            if (i == 11) checkOutput("rst_we_next", 32'(bram_we), 32'd0);
            if (i == 14) rst = 1'b0;
            step();
        end
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("abort_writes", 32'(wr_addr.size()),  32'd20);
        checkOutput("abort_busy",   32'(busy),            32'd0);
        checkOutput("abort_de",     32'(display_enable),  32'd0);
        checkOutput("abort_pcnt",   32'(pixel_count),     32'd0);
        checkOutput("abort_addr",   32'(bram_addr),       32'd0);
        checkOutput("abort_wdata",  32'(bram_wdata),      32'd0);
        checkOutput("abort_done",   32'(done_count),      32'd1);
        checkOutput("we_outside2",  32'(we_outside),      32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
